pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage core (IF/ID/EX/MEM/WB).
- Generates per-stage stall/flush, the interrupt-detect strobe consumed by EX, and the redirect PC.
- Commits exceptions and EXRT at MEM, and owns the 8-entry control-register file (read by ID, written by WRCR at MEM).

Parameters:
- IRQ_W, 8, number of external interrupt lines.
- RESET_VECTOR, 30'h0, word address loaded into EXP_VECTOR on reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- irq  in  IRQ_W  level-sensitive interrupt requests
- if_busy  in  1  IF bus access pending
- mem_busy  in  1  MEM bus access pending
- ld_hazard  in  1  load-use hazard detected in ID
- mem_pc  in  30  MEM-stage word PC
- mem_en  in  1  MEM-stage data valid
- mem_br_flag  in  1  MEM instruction sits in a branch delay slot
- mem_ctrl_op  in  2  0 NOP, 1 WRCR, 2 EXRT, 3 reserved (treated as NOP)
- mem_dst_addr  in  5  control-register address for WRCR
- mem_exp_code  in  3  0 none, 1 INT, 2 UNDEF, 3 OVF, 4 MISALIGN, 5 TRAP, 6 PRV
- mem_out  in  32  WRCR write data
- creg_rd_addr  in  5  ID read address
- creg_rd_data  out  32  combinational read data
- exe_mode  out  1  STATUS[0]: 0 kernel, 1 user
- if_stall / id_stall / ex_stall / mem_stall  out  1 each  stage stalls
- if_flush / id_flush / ex_flush / mem_flush  out  1 each  stage flushes
- int_detect  out  1  interrupt accepted, to EX
- new_pc  out  30  redirect target, valid while if_flush=1

Behaviour:
- Control registers (addr[2:0]; addresses 8-31 read 0, writes ignored):
  - 0 STATUS{int_en[1], exe_mode[0]}
  - 1 PRE_STATUS
  - 2 reserved (reads 0)
  - 3 INT_MASK[IRQ_W-1:0], 1 = masked
  - 4 IRQ (read-only, live irq)
  - 5 EPC[31:2]
  - 6 EXP_VECTOR[31:2]
  - 7 CAUSE{br_flag[3], exp_code[2:0]}
- Reset values: all registers 0, except INT_MASK all-ones and EXP_VECTOR = RESET_VECTOR. Output state: FSM RUN, all flush outputs 0, new_pc 0.
- Stalls (combinational): busy = if_busy | mem_busy.
  - if_stall = busy | ld_hazard
  - id_stall = ex_stall = mem_stall = busy
- int_detect = STATUS.int_en & |(irq & ~INT_MASK). Combinational; EX converts its slot into exp_code 1.
- FSM states RUN and REDIRECT.
  - Commit event at a posedge in RUN, when mem_en=1 and mem_stall=0:
    - EXC: mem_exp_code!=0.
      - PRE_STATUS<=STATUS, STATUS<=0 (kernel mode, interrupts off).
      - EPC <= mem_br_flag ? mem_pc-1 : mem_pc (30-bit wrap).
      - CAUSE <= {mem_br_flag, mem_exp_code}.
      - new_pc <= EXP_VECTOR; go to REDIRECT.
    - EXRT: exp_code==0, ctrl_op==2.
      - STATUS<=PRE_STATUS, new_pc<=EPC; go to REDIRECT.
    - WRCR: exp_code==0, ctrl_op==1, addr ∈ {0,1,3,5,6,7}.
      - Write mem_out; stay in RUN.
      - WRCR while exe_mode=1 is a silent no-op (privilege checking is upstream).
  - EXC has priority over ctrl_op in the same slot.
- REDIRECT (exactly 1 cycle): all four flush outputs = 1, new_pc held. Then return to RUN.
  - Commits are ignored in REDIRECT; the flushed slot is discarded.
  - If busy during REDIRECT, flushes still assert and the FSM returns to RUN. Stages give flush priority over stall.
- id_flush additionally asserts in RUN when ld_hazard=1 and busy=0 (bubble insertion). The other flushes stay 0.
- Read port bypass: a WRCR committing this cycle to creg_rd_addr is forwarded to creg_rd_data.
- Reset mid-REDIRECT returns to RUN with flushes deasserted immediately (async).

Decomposition:
- Shared package/header: exp_code constants, ctrl_op constants, control-register address constants, STATUS bit indices, WORD/WORD_ADDR widths.
- One sub-module: pipe_ctrl_creg (register file, read mux, bypass). The FSM and stall/flush logic stay in pipe_ctrl.

Test Plan:
- Reset release → INT_MASK=8'hFF, EXP_VECTOR=RESET_VECTOR, all flush/stall=0, int_detect=0 even with irq=8'h01.
- WRCR addr 0 data 2, then WRCR addr 3 data 8'hFE, then irq=8'h01 → int_detect=1; irq=8'h02 alone → int_detect=0.
- mem_exp_code=3, mem_pc=30'h100, br_flag=1, EXP_VECTOR=30'h40 → next cycle all flushes=1, new_pc=30'h40; EPC=30'hFF; CAUSE=4'hB; STATUS=0; one cycle later flushes=0.
- EXRT with EPC=30'h200, PRE_STATUS=2 → 1-cycle flush, new_pc=30'h200, STATUS=2.
- mem_busy=1 together with an exception → no commit and all stalls=1 while busy; commit occurs on the first cycle busy=0.
- ld_hazard=1, busy=0 → if_stall=1, id_flush=1, ex_stall=0; same with if_busy=1 → id_flush=0, all stalls=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: widths, exception codes,
// MEM-stage control ops, control-register addresses and STATUS bit positions.
package pipe_ctrl_pkg;

  localparam int WORD      = 32;
  localparam int WORD_ADDR = 30;

  // Exception codes carried down the pipe to MEM
  localparam logic [2:0] EXP_NONE     = 3'd0;
  localparam logic [2:0] EXP_INT      = 3'd1;
  localparam logic [2:0] EXP_UNDEF    = 3'd2;
  localparam logic [2:0] EXP_OVF      = 3'd3;
  localparam logic [2:0] EXP_MISALIGN = 3'd4;
  localparam logic [2:0] EXP_TRAP     = 3'd5;
  localparam logic [2:0] EXP_PRV      = 3'd6;

  // MEM-stage control operations (code 3 is reserved and behaves as NOP)
  localparam logic [1:0] CTRL_NOP  = 2'd0;
  localparam logic [1:0] CTRL_WRCR = 2'd1;
  localparam logic [1:0] CTRL_EXRT = 2'd2;

  // Control-register addresses (low three bits of the 5-bit address)
  localparam logic [2:0] CREG_STATUS     = 3'd0;
  localparam logic [2:0] CREG_PRE_STATUS = 3'd1;
  localparam logic [2:0] CREG_RSVD       = 3'd2;
  localparam logic [2:0] CREG_INT_MASK   = 3'd3;
  localparam logic [2:0] CREG_IRQ        = 3'd4;
  localparam logic [2:0] CREG_EPC        = 3'd5;
  localparam logic [2:0] CREG_EXP_VECTOR = 3'd6;
  localparam logic [2:0] CREG_CAUSE      = 3'd7;

  // STATUS bit positions
  localparam int STATUS_EXE_MODE = 0;
  localparam int STATUS_INT_EN   = 1;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_ctrl_creg.sv
// Control-register file: STATUS, PRE_STATUS, INT_MASK, EPC, EXP_VECTOR, CAUSE,
// plus the live IRQ view. Exception entry/return update the registers directly;
// WRCR writes are forwarded to the combinational read port in the same cycle.
module pipe_ctrl_creg
  import pipe_ctrl_pkg::*;
#(
  parameter int              IRQ_W        = 8,
  parameter logic [29:0]     RESET_VECTOR = 30'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IRQ_W-1:0]     irq,
  input  logic                 wr_en,
  input  logic [4:0]           wr_addr,
  input  logic [WORD-1:0]      wr_data,
  input  logic                 exc_en,
  input  logic                 exrt_en,
  input  logic [WORD_ADDR-1:0] exc_pc,
  input  logic                 exc_br_flag,
  input  logic [2:0]           exc_code,
  input  logic [4:0]           rd_addr,
  output logic [WORD-1:0]      rd_data,
  output logic [1:0]           status,
  output logic [IRQ_W-1:0]     int_mask,
  output logic [WORD_ADDR-1:0] epc,
  output logic [WORD_ADDR-1:0] exp_vector
);

  logic [1:0]           status_reg;
  logic [1:0]           pre_status_reg;
  logic [IRQ_W-1:0]     int_mask_reg;
  logic [WORD_ADDR-1:0] epc_reg;
  logic [WORD_ADDR-1:0] exp_vector_reg;
  logic [3:0]           cause_reg;

  // Addresses 8-31 are unmapped, so only the low bank can be written
  logic wr_hit;
  logic wr_status, wr_pre_status, wr_int_mask, wr_epc, wr_exp_vector, wr_cause;

  assign wr_hit        = wr_en && (wr_addr[4:3] == 2'b00);
  assign wr_status     = wr_hit && (wr_addr[2:0] == CREG_STATUS);
  assign wr_pre_status = wr_hit && (wr_addr[2:0] == CREG_PRE_STATUS);
  assign wr_int_mask   = wr_hit && (wr_addr[2:0] == CREG_INT_MASK);
  assign wr_epc        = wr_hit && (wr_addr[2:0] == CREG_EPC);
  assign wr_exp_vector = wr_hit && (wr_addr[2:0] == CREG_EXP_VECTOR);
  assign wr_cause      = wr_hit && (wr_addr[2:0] == CREG_CAUSE);

  // Register updates: exception entry, exception return, or a WRCR write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_reg     <= '0;
      pre_status_reg <= '0;
      int_mask_reg   <= '1;
      epc_reg        <= '0;
      exp_vector_reg <= RESET_VECTOR;
      cause_reg      <= '0;
    end else if (exc_en) begin
      pre_status_reg <= status_reg;
      status_reg     <= '0;
      epc_reg        <= exc_br_flag ? (exc_pc - 30'd1) : exc_pc;
      cause_reg      <= {exc_br_flag, exc_code};
    end else if (exrt_en) begin
      status_reg <= pre_status_reg;
    end else begin
      if (wr_status)     status_reg     <= wr_data[1:0];
      if (wr_pre_status) pre_status_reg <= wr_data[1:0];
      if (wr_int_mask)   int_mask_reg   <= wr_data[IRQ_W-1:0];
      if (wr_epc)        epc_reg        <= wr_data[WORD-1:2];
      if (wr_exp_vector) exp_vector_reg <= wr_data[WORD-1:2];
      if (wr_cause)      cause_reg      <= wr_data[3:0];
    end
  end

  // Read mux over the post-write view so a same-cycle WRCR is forwarded to ID
  always_comb begin
    rd_data = '0;
    if (rd_addr[4:3] == 2'b00) begin
      case (rd_addr[2:0])
        CREG_STATUS:     rd_data[1:0] = wr_status ? wr_data[1:0] : status_reg;
        CREG_PRE_STATUS: rd_data[1:0] = wr_pre_status ? wr_data[1:0] : pre_status_reg;
        CREG_INT_MASK:   rd_data[IRQ_W-1:0] = wr_int_mask ? wr_data[IRQ_W-1:0] : int_mask_reg;
        CREG_IRQ:        rd_data[IRQ_W-1:0] = irq;
        CREG_EPC:        rd_data[WORD-1:2] = wr_epc ? wr_data[WORD-1:2] : epc_reg;
        CREG_EXP_VECTOR: rd_data[WORD-1:2] = wr_exp_vector ? wr_data[WORD-1:2] : exp_vector_reg;
        CREG_CAUSE:      rd_data[3:0] = wr_cause ? wr_data[3:0] : cause_reg;
        default:         rd_data = '0;
      endcase
    end
  end

  assign status     = status_reg;
  assign int_mask   = int_mask_reg;
  assign epc        = epc_reg;
  assign exp_vector = exp_vector_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage stall/flush generation, interrupt detect,
// MEM-stage commit of exceptions / EXRT / WRCR, and the one-cycle redirect.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          IRQ_W        = 8,
  parameter logic [29:0] RESET_VECTOR = 30'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IRQ_W-1:0]     irq,
  input  logic                 if_busy,
  input  logic                 mem_busy,
  input  logic                 ld_hazard,
  input  logic [WORD_ADDR-1:0] mem_pc,
  input  logic                 mem_en,
  input  logic                 mem_br_flag,
  input  logic [1:0]           mem_ctrl_op,
  input  logic [4:0]           mem_dst_addr,
  input  logic [2:0]           mem_exp_code,
  input  logic [WORD-1:0]      mem_out,
  input  logic [4:0]           creg_rd_addr,
  output logic [WORD-1:0]      creg_rd_data,
  output logic                 exe_mode,
  output logic                 if_stall,
  output logic                 id_stall,
  output logic                 ex_stall,
  output logic                 mem_stall,
  output logic                 if_flush,
  output logic                 id_flush,
  output logic                 ex_flush,
  output logic                 mem_flush,
  output logic                 int_detect,
  output logic [WORD_ADDR-1:0] new_pc
);

  state_t               state_reg, state_next;
  logic [WORD_ADDR-1:0] new_pc_reg, new_pc_next;

  logic                 busy;
  logic                 commit;
  logic                 exc_en, exrt_en, wr_en;
  logic [1:0]           status;
  logic [IRQ_W-1:0]     int_mask;
  logic [WORD_ADDR-1:0] epc;
  logic [WORD_ADDR-1:0] exp_vector;

  assign busy      = if_busy | mem_busy;
  assign if_stall  = busy | ld_hazard;
  assign id_stall  = busy;
  assign ex_stall  = busy;
  assign mem_stall = busy;

  assign exe_mode   = status[STATUS_EXE_MODE];
  assign int_detect = status[STATUS_INT_EN] & (|(irq & ~int_mask));

  // A MEM slot commits only in RUN, when valid and not held by a stall.
  // Exceptions win over ctrl_op; WRCR from user mode is dropped silently.
  assign commit  = (state_reg == ST_RUN) && mem_en && !mem_stall;
  assign exc_en  = commit && (mem_exp_code != EXP_NONE);
  assign exrt_en = commit && (mem_exp_code == EXP_NONE) && (mem_ctrl_op == CTRL_EXRT);
  assign wr_en   = commit && (mem_exp_code == EXP_NONE) && (mem_ctrl_op == CTRL_WRCR)
                   && !status[STATUS_EXE_MODE];

  pipe_ctrl_creg #(
    .IRQ_W        (IRQ_W),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_creg (
    .clk         (clk),
    .rst         (rst),
    .irq         (irq),
    .wr_en       (wr_en),
    .wr_addr     (mem_dst_addr),
    .wr_data     (mem_out),
    .exc_en      (exc_en),
    .exrt_en     (exrt_en),
    .exc_pc      (mem_pc),
    .exc_br_flag (mem_br_flag),
    .exc_code    (mem_exp_code),
    .rd_addr     (creg_rd_addr),
    .rd_data     (creg_rd_data),
    .status      (status),
    .int_mask    (int_mask),
    .epc         (epc),
    .exp_vector  (exp_vector)
  );

  // State and redirect-target registers; async reset clears flushes at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_RUN;
      new_pc_reg <= '0;
    end else begin
      state_reg  <= state_next;
      new_pc_reg <= new_pc_next;
    end
  end

  // Next-state and flush decode: REDIRECT lasts one cycle regardless of busy
  always_comb begin
    state_next  = state_reg;
    new_pc_next = new_pc_reg;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    ex_flush    = 1'b0;
    mem_flush   = 1'b0;
    case (state_reg)
      ST_RUN: begin
        id_flush = ld_hazard & ~busy;
        if (exc_en) begin
          new_pc_next = exp_vector;
          state_next  = ST_REDIRECT;
        end else if (exrt_en) begin
          new_pc_next = epc;
          state_next  = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if_flush   = 1'b1;
        id_flush   = 1'b1;
        ex_flush   = 1'b1;
        mem_flush  = 1'b1;
        state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  assign new_pc = new_pc_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: hand-computed expectations, one line per check.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  irq;
  logic        if_busy, mem_busy, ld_hazard;
  logic [29:0] mem_pc;
  logic        mem_en, mem_br_flag;
  logic [1:0]  mem_ctrl_op;
  logic [4:0]  mem_dst_addr;
  logic [2:0]  mem_exp_code;
  logic [31:0] mem_out;
  logic [4:0]  creg_rd_addr;
  logic [31:0] creg_rd_data;
  logic        exe_mode;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic        int_detect;
  logic [29:0] new_pc;

  int checks_cnt = 0;
  int errors_cnt = 0;

  pipe_ctrl #(
    .IRQ_W        (8),
    .RESET_VECTOR (30'h40)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .irq          (irq),
    .if_busy      (if_busy),
    .mem_busy     (mem_busy),
    .ld_hazard    (ld_hazard),
    .mem_pc       (mem_pc),
    .mem_en       (mem_en),
    .mem_br_flag  (mem_br_flag),
    .mem_ctrl_op  (mem_ctrl_op),
    .mem_dst_addr (mem_dst_addr),
    .mem_exp_code (mem_exp_code),
    .mem_out      (mem_out),
    .creg_rd_addr (creg_rd_addr),
    .creg_rd_data (creg_rd_data),
    .exe_mode     (exe_mode),
    .if_stall     (if_stall),
    .id_stall     (id_stall),
    .ex_stall     (ex_stall),
    .mem_stall    (mem_stall),
    .if_flush     (if_flush),
    .id_flush     (id_flush),
    .ex_flush     (ex_flush),
    .mem_flush    (mem_flush),
    .int_detect   (int_detect),
    .new_pc       (new_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    creg_rd_addr = addr;
    #1;
    chk(tag, creg_rd_data, exp);
  endtask

  task automatic wrcr(input logic [4:0] addr, input logic [31:0] data);
    mem_en       = 1'b1;
    mem_ctrl_op  = 2'd1;
    mem_dst_addr = addr;
    mem_out      = data;
    mem_exp_code = 3'd0;
    step();
    mem_en      = 1'b0;
    mem_ctrl_op = 2'd0;
  endtask

  function automatic logic [3:0] flushes();
    return {if_flush, id_flush, ex_flush, mem_flush};
  endfunction

  function automatic logic [3:0] stalls();
    return {if_stall, id_stall, ex_stall, mem_stall};
  endfunction

  initial begin
    rst = 1'b0; irq = 8'h01;
    if_busy = 0; mem_busy = 0; ld_hazard = 0;
    mem_pc = '0; mem_en = 0; mem_br_flag = 0; mem_ctrl_op = 0;
    mem_dst_addr = 0; mem_exp_code = 0; mem_out = 0; creg_rd_addr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;

    // reset state
    chk("rst_flush", 32'(flushes()), 32'h0);
    chk("rst_stall", 32'(stalls()), 32'h0);
    chk("rst_int_detect", 32'(int_detect), 32'h0);
    chk("rst_new_pc", 32'(new_pc), 32'h0);
    rd(5'd3, 32'h0000_00FF, "rst_int_mask");
    rd(5'd6, 32'h0000_0100, "rst_exp_vector");
    rd(5'd0, 32'h0, "rst_status");
    step();

    // WRCR STATUS=2 with same-cycle bypass to the read port
    creg_rd_addr = 5'd0;
    mem_en = 1; mem_ctrl_op = 2'd1; mem_dst_addr = 5'd0; mem_out = 32'h2; mem_exp_code = 0;
    #1 chk("bypass_status", creg_rd_data, 32'h2);
    step();
    mem_en = 0; mem_ctrl_op = 0;
    rd(5'd0, 32'h2, "status_after_wr");
    wrcr(5'd3, 32'h0000_00FE);
    irq = 8'h01; #1 chk("int_detect_unmasked", 32'(int_detect), 32'h1);
    irq = 8'h02; #1 chk("int_detect_masked", 32'(int_detect), 32'h0);
    rd(5'd4, 32'h0000_0002, "irq_live");

    // reserved and unmapped addresses read 0 and ignore writes
    wrcr(5'd2, 32'hFFFF_FFFF);
    rd(5'd2, 32'h0, "rsvd_reads_0");
    wrcr(5'd11, 32'hFFFF_FFFF);
    rd(5'd11, 32'h0, "unmapped_reads_0");
    rd(5'd3, 32'h0000_00FE, "int_mask_kept");

    // OVF in a delay slot: EPC = pc-1, CAUSE = {1,3}
    mem_en = 1; mem_exp_code = 3'd3; mem_pc = 30'h100; mem_br_flag = 1;
    step();
    mem_en = 0; mem_exp_code = 0; mem_br_flag = 0;
    chk("exc_flush", 32'(flushes()), 32'hF);
    chk("exc_new_pc", 32'(new_pc), 32'h40);
    rd(5'd5, 32'h0000_03FC, "exc_epc");
    rd(5'd7, 32'h0000_000B, "exc_cause");
    rd(5'd0, 32'h0, "exc_status");
    rd(5'd1, 32'h2, "exc_pre_status");
    step();
    chk("exc_flush_end", 32'(flushes()), 32'h0);

    // EXRT back to EPC=0x200, STATUS restored from PRE_STATUS
    wrcr(5'd5, 32'h0000_0800);
    mem_en = 1; mem_ctrl_op = 2'd2;
    step();
    chk("exrt_flush", 32'(flushes()), 32'hF);
    chk("exrt_new_pc", 32'(new_pc), 32'h200);
    rd(5'd0, 32'h2, "exrt_status");
    // a WRCR presented during REDIRECT is discarded
    mem_ctrl_op = 2'd1; mem_dst_addr = 5'd6; mem_out = 32'h0;
    step();
    mem_en = 0; mem_ctrl_op = 0;
    chk("exrt_flush_end", 32'(flushes()), 32'h0);
    rd(5'd6, 32'h0000_0100, "redirect_wr_ignored");

    // exception held by mem_busy commits on the first non-busy cycle
    mem_busy = 1; mem_en = 1; mem_exp_code = 3'd5; mem_pc = 30'h10;
    #1 chk("busy_stalls", 32'(stalls()), 32'hF);
    step();
    chk("busy_no_commit", 32'(flushes()), 32'h0);
    rd(5'd7, 32'h0000_000B, "busy_cause_kept");
    mem_busy = 0;
    step();
    mem_en = 0; mem_exp_code = 0;
    chk("busy_commit_flush", 32'(flushes()), 32'hF);
    rd(5'd7, 32'h0000_0005, "busy_commit_cause");
    rd(5'd5, 32'h0000_0040, "busy_commit_epc");
    step();

    // load-use hazard: bubble when not busy, plain stall when busy
    ld_hazard = 1;
    #1 chk("ldh_stalls", 32'(stalls()), 32'h8);
    chk("ldh_flushes", 32'(flushes()), 32'h4);
    if_busy = 1;
    #1 chk("ldh_busy_stalls", 32'(stalls()), 32'hF);
    chk("ldh_busy_flushes", 32'(flushes()), 32'h0);
    ld_hazard = 0; if_busy = 0;
    step();

    // user mode: WRCR is a silent no-op (no bypass either)
    wrcr(5'd0, 32'h1);
    chk("user_mode", 32'(exe_mode), 32'h1);
    creg_rd_addr = 5'd3;
    mem_en = 1; mem_ctrl_op = 2'd1; mem_dst_addr = 5'd3; mem_out = 32'h0;
    #1 chk("user_no_bypass", creg_rd_data, 32'h0000_00FE);
    step();
    mem_en = 0; mem_ctrl_op = 0;
    rd(5'd3, 32'h0000_00FE, "user_wr_ignored");

    // asynchronous reset in the middle of REDIRECT
    mem_en = 1; mem_exp_code = 3'd1; mem_pc = 30'h20;
    step();
    mem_en = 0; mem_exp_code = 0;
    chk("pre_rst_flush", 32'(flushes()), 32'hF);
    #2 rst = 1'b0;
    #1 chk("async_rst_flush", 32'(flushes()), 32'h0);
    chk("async_rst_new_pc", 32'(new_pc), 32'h0);
    #3 rst = 1'b1;
    step();
    chk("post_rst_flush", 32'(flushes()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
